// File: rtl/ah_decode_route_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ah_decode_route_ctrl_if: config, ingress, dispatch, error bundle  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface ah_decode_route_ctrl_if #(
  parameter int NUM_CLIENTS = 10,
  parameter int ADDR_W      = 34,
  parameter int IDX_W       = 4,
  parameter int ERR_CNT_W   = 16
);
  logic                   cfg_wr_en;
  logic [IDX_W-1:0]       cfg_idx;
  logic [ADDR_W-1:0]      cfg_base;
  logic [ADDR_W-1:0]      cfg_limit;
  logic                   cfg_enable;
  logic                   cfg_ready;
  logic                   req_valid;
  logic                   req_ready;
  logic [ADDR_W-1:0]      ingress_pkt_field;
  logic [NUM_CLIENTS-1:0] dsp_valid;
  logic [NUM_CLIENTS-1:0] dsp_ready;
  logic [ADDR_W-1:0]      dsp_addr;
  logic                   dec_err;
  logic [ADDR_W-1:0]      err_addr;
  logic [ERR_CNT_W-1:0]   err_count;
  logic                   busy;

  modport slave (
    input  cfg_wr_en, cfg_idx, cfg_base, cfg_limit, cfg_enable,
    input  req_valid, ingress_pkt_field, dsp_ready,
    output cfg_ready, req_ready, dsp_valid, dsp_addr,
    output dec_err, err_addr, err_count, busy
  );

  modport master (
    output cfg_wr_en, cfg_idx, cfg_base, cfg_limit, cfg_enable,
    output req_valid, ingress_pkt_field, dsp_ready,
    input  cfg_ready, req_ready, dsp_valid, dsp_addr,
    input  dec_err, err_addr, err_count, busy
  );
endinterface
`default_nettype wire

// File: rtl/ah_decode_route_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ah_decode_route_ctrl: window address decoder and request router   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module ah_decode_route_ctrl #(
  parameter int NUM_CLIENTS = 10,
  parameter int ADDR_W      = 34,
  parameter int IDX_W       = 4,
  parameter int ERR_CNT_W   = 16
) (
  input wire clk,
  input wire rst,
  ah_decode_route_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DECODE   = 2'd1,
    DISPATCH = 2'd2,
    ERROR    = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [NUM_CLIENTS-1:0] sel_q, sel_d;
  logic [ADDR_W-1:0]      base_q  [NUM_CLIENTS];
  logic [ADDR_W-1:0]      base_d  [NUM_CLIENTS];
  logic [ADDR_W-1:0]      limit_q [NUM_CLIENTS];
  logic [ADDR_W-1:0]      limit_d [NUM_CLIENTS];
  logic [NUM_CLIENTS-1:0] en_q, en_d;
  logic [ADDR_W-1:0]      err_addr_q, err_addr_d;
  logic [ERR_CNT_W-1:0]   err_count_q, err_count_d;

  logic                   idle;
  logic                   cfg_accept;
  logic                   req_accept;
  logic                   hit;
  logic [NUM_CLIENTS-1:0] match_sel;

  assign idle       = (state_q == IDLE);
  assign cfg_accept = idle & bus.cfg_wr_en;
  assign req_accept = idle & ~bus.cfg_wr_en & bus.req_valid;

  // First matching index wins; an inverted window (base > limit) can never satisfy both bounds.
  always_comb begin
    hit       = 1'b0;
    match_sel = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (!hit && en_q[i] && (addr_q >= base_q[i]) && (addr_q <= limit_q[i])) begin
        match_sel[i] = 1'b1;
        hit          = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    sel_d       = sel_q;
    base_d      = base_q;
    limit_d     = limit_q;
    en_d        = en_q;
    err_addr_d  = err_addr_q;
    err_count_d = err_count_q;

    // Out-of-range indices match no entry and are silently dropped.
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (cfg_accept && (bus.cfg_idx == IDX_W'(i))) begin
        base_d[i]  = bus.cfg_base;
        limit_d[i] = bus.cfg_limit;
        en_d[i]    = bus.cfg_enable;
      end
    end

    case (state_q)
      IDLE: begin
        if (req_accept) begin
          addr_d  = bus.ingress_pkt_field;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (hit) begin
          sel_d   = match_sel;
          state_d = DISPATCH;
        end else begin
          // Error status is loaded here so it is visible alongside the dec_err pulse.
          err_addr_d = addr_q;
          if (err_count_q != '1) begin
            err_count_d = err_count_q + ERR_CNT_W'(1);
          end
          state_d = ERROR;
        end
      end
      DISPATCH: begin
        if (|(bus.dsp_ready & sel_q)) begin
          sel_d   = '0;
          state_d = IDLE;
        end
      end
      ERROR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      sel_q       <= '0;
      en_q        <= '0;
      err_addr_q  <= '0;
      err_count_q <= '0;
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        base_q[i]  <= '0;
        limit_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      sel_q       <= sel_d;
      en_q        <= en_d;
      err_addr_q  <= err_addr_d;
      err_count_q <= err_count_d;
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        base_q[i]  <= base_d[i];
        limit_q[i] <= limit_d[i];
      end
    end
  end

  assign bus.cfg_ready = idle;
  assign bus.req_ready = idle & ~bus.cfg_wr_en;
  assign bus.dsp_valid = (state_q == DISPATCH) ? sel_q : '0;
  assign bus.dsp_addr  = addr_q;
  assign bus.dec_err   = (state_q == ERROR);
  assign bus.err_addr  = err_addr_q;
  assign bus.err_count = err_count_q;
  assign bus.busy      = ~idle;

endmodule
`default_nettype wire

// File: tb/tb_ah_decode_route_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_ah_decode_route_ctrl: scoreboard bench for the decode router   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_ah_decode_route_ctrl;

  localparam int NC = 10;
  localparam int AW = 34;
  localparam int IW = 4;
  localparam int EW = 16;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic rst2 = 1'b1;
  always #5 clk = ~clk;

  ah_decode_route_ctrl_if #(.NUM_CLIENTS(NC), .ADDR_W(AW), .IDX_W(IW), .ERR_CNT_W(EW)) u_if ();
  ah_decode_route_ctrl_if #(.NUM_CLIENTS(2), .ADDR_W(AW), .IDX_W(1), .ERR_CNT_W(4)) s_if ();

  ah_decode_route_ctrl #(.NUM_CLIENTS(NC), .ADDR_W(AW), .IDX_W(IW), .ERR_CNT_W(EW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  // Narrow-counter instance so saturation is reachable in a short run.
  ah_decode_route_ctrl #(.NUM_CLIENTS(2), .ADDR_W(AW), .IDX_W(1), .ERR_CNT_W(4)) u_dut_sat (
    .clk (clk),
    .rst (rst2),
    .bus (s_if)
  );

  typedef struct {
    bit            err;
    logic [NC-1:0] sel;
    logic [AW-1:0] addr;
    logic [EW-1:0] cnt;
    int            cyc;
  } exp_t;

  exp_t sbq[$];
  int   checks  = 0;
  int   errors  = 0;
  int   cyc     = 0;
  int   exp_err = 0;
  logic prev_v  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: one scoreboard entry per dec_err pulse or per rising dsp_valid.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      prev_v <= 1'b0;
    end else begin
      if (u_if.dec_err || ((|u_if.dsp_valid) && !prev_v)) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: dsp_valid 0x%0h dec_err %0b, expected nothing",
                   u_if.dsp_valid, u_if.dec_err);
        end else begin
          e = sbq.pop_front();
          chk("latency", 64'(cyc), 64'(e.cyc + 2));
          chk("dec_err", 64'(u_if.dec_err), 64'(e.err));
          if (e.err) begin
            chk("err_addr", 64'(u_if.err_addr), 64'(e.addr));
            chk("err_count", 64'(u_if.err_count), 64'(e.cnt));
          end else begin
            chk("dsp_valid", 64'(u_if.dsp_valid), 64'(e.sel));
            chk("dsp_addr", 64'(u_if.dsp_addr), 64'(e.addr));
          end
        end
      end
      prev_v <= |u_if.dsp_valid;
    end
  end

  task automatic cfg_write(input logic [IW-1:0] idx, input logic [AW-1:0] b,
                           input logic [AW-1:0] l, input logic en);
    @(negedge clk);
    u_if.cfg_wr_en  = 1'b1;
    u_if.cfg_idx    = idx;
    u_if.cfg_base   = b;
    u_if.cfg_limit  = l;
    u_if.cfg_enable = en;
    @(posedge clk);
    #1 u_if.cfg_wr_en = 1'b0;
  endtask

  task automatic send_req(input logic [AW-1:0] a, input bit err, input logic [NC-1:0] sel);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    u_if.req_valid         = 1'b1;
    u_if.ingress_pkt_field = a;
    while (!u_if.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!u_if.req_ready) begin
      checks++;
      errors++;
      $display("FAIL req_accept_timeout: req_ready 0 expected 1 for field 0x%0h", a);
      u_if.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (err && exp_err != 'hFFFF) exp_err++;
    e.err  = err;
    e.sel  = sel;
    e.addr = a;
    e.cnt  = EW'(exp_err);
    e.cyc  = cyc;
    sbq.push_back(e);
    #1 u_if.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (u_if.busy && n < 200);
    if (u_if.busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy 1 expected 0");
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int seen;
    int n;
    u_if.cfg_wr_en = 0; u_if.cfg_idx = '0; u_if.cfg_base = '0; u_if.cfg_limit = '0;
    u_if.cfg_enable = 0; u_if.req_valid = 0; u_if.ingress_pkt_field = '0; u_if.dsp_ready = '1;
    s_if.cfg_wr_en = 0; s_if.cfg_idx = '0; s_if.cfg_base = '0; s_if.cfg_limit = '0;
    s_if.cfg_enable = 0; s_if.req_valid = 0; s_if.ingress_pkt_field = 34'h3_0000_0123;
    s_if.dsp_ready = '0;

    repeat (3) @(negedge clk);
    rst = 1'b0; rst2 = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(u_if.busy), 0);
    chk("rst_dsp_valid", 64'(u_if.dsp_valid), 0);
    chk("rst_dsp_addr", 64'(u_if.dsp_addr), 0);
    chk("rst_dec_err", 64'(u_if.dec_err), 0);
    chk("rst_err_addr", 64'(u_if.err_addr), 0);
    chk("rst_err_count", 64'(u_if.err_count), 0);
    chk("rst_cfg_ready", 64'(u_if.cfg_ready), 1);
    chk("rst_req_ready", 64'(u_if.req_ready), 1);

    // Saturation on the 4-bit counter instance: nothing enabled, every request misses.
    s_if.req_valid = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      seen = 0;
      n    = 0;
      while (!seen && n < 20) begin
        @(negedge clk);
        n++;
        if (s_if.dec_err) seen = 1;
      end
      chk("sat_pulse_seen", 64'(seen), 1);
      chk("sat_err_count", 64'(s_if.err_count), (k > 15) ? 64'd15 : 64'(k));
    end
    chk("sat_err_addr", 64'(s_if.err_addr), 64'h3_0000_0123);
    s_if.req_valid = 1'b0;

    // Single window, immediate ready, one-cycle dispatch.
    cfg_write(0, 34'h0_0000_0000, 34'h0_0000_0FFF, 1);
    send_req(34'h0_0000_0800, 0, 10'b00_0000_0001);
    @(negedge clk);
    @(negedge clk);
    chk("t1_valid_n2", 64'(u_if.dsp_valid), 64'h001);
    @(negedge clk);
    chk("t1_valid_n3", 64'(u_if.dsp_valid), 0);
    chk("t1_req_ready_n3", 64'(u_if.req_ready), 1);

    // Overlapping windows and inclusive boundaries.
    cfg_write(1, 34'h1000, 34'h3FFF, 1);
    cfg_write(2, 34'h2000, 34'h5FFF, 1);
    send_req(34'h2800, 0, 10'b00_0000_0010); wait_idle();
    send_req(34'h4000, 0, 10'b00_0000_0100); wait_idle();
    send_req(34'h1000, 0, 10'b00_0000_0010); wait_idle();
    send_req(34'h3FFF, 0, 10'b00_0000_0010); wait_idle();
    send_req(34'h0FFF, 0, 10'b00_0000_0001); wait_idle();
    send_req(34'h6000, 1, '0);               wait_idle();

    // Backpressure on client 3 while client 4's ready toggles.
    cfg_write(3, 34'h7000, 34'h7FFF, 1);
    u_if.dsp_ready = '0;
    send_req(34'h7123, 0, 10'b00_0000_1000);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(u_if.dsp_valid), 64'h008);
      chk("bp_addr", 64'(u_if.dsp_addr), 64'h7123);
      chk("bp_req_ready", 64'(u_if.req_ready), 0);
      chk("bp_busy", 64'(u_if.busy), 1);
      u_if.dsp_ready[4] = ~u_if.dsp_ready[4];
      @(negedge clk);
    end
    u_if.dsp_ready[3] = 1'b1;
    chk("bp_valid_last", 64'(u_if.dsp_valid), 64'h008);
    @(negedge clk);
    chk("bp_done_valid", 64'(u_if.dsp_valid), 0);
    chk("bp_done_busy", 64'(u_if.busy), 0);
    u_if.dsp_ready = '1;

    // Config write and request in the same IDLE cycle.
    @(negedge clk);
    u_if.cfg_wr_en = 1'b1; u_if.cfg_idx = 4'd6; u_if.cfg_base = 34'h9000;
    u_if.cfg_limit = 34'h9FFF; u_if.cfg_enable = 1'b1;
    u_if.req_valid = 1'b1; u_if.ingress_pkt_field = 34'h9800;
    #1;
    chk("coll_req_ready", 64'(u_if.req_ready), 0);
    chk("coll_cfg_ready", 64'(u_if.cfg_ready), 1);
    @(posedge clk);
    #1 u_if.cfg_wr_en = 1'b0;
    send_req(34'h9800, 0, 10'b00_0100_0000); wait_idle();

    cfg_write(4'd12, 34'hA000, 34'hAFFF, 1);
    send_req(34'hA800, 1, '0); wait_idle();

    // Inverted enabled window and disabled catch-all window.
    cfg_write(2, 34'h5000, 34'h4000, 1);
    cfg_write(8, 34'h0, 34'h3_FFFF_FFFF, 0);
    send_req(34'h4800, 1, '0);               wait_idle();
    send_req(34'h5000, 1, '0);               wait_idle();
    send_req(34'h4000, 1, '0);               wait_idle();
    send_req(34'h3FFF, 0, 10'b00_0000_0010); wait_idle();

    // Asynchronous reset while client 5 is stalled.
    cfg_write(5, 34'hB000, 34'hBFFF, 1);
    u_if.dsp_ready = '0;
    send_req(34'hB400, 0, 10'b00_0010_0000);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_valid", 64'(u_if.dsp_valid), 64'h020);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 64'(u_if.dsp_valid), 0);
    chk("async_rst_busy", 64'(u_if.busy), 0);
    chk("async_rst_err_count", 64'(u_if.err_count), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_err = 0;
    u_if.dsp_ready = '1;
    send_req(34'hB400, 1, '0);       wait_idle();
    send_req(34'h0_0000_0800, 1, '0); wait_idle();

    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(sbq.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ah_decode_route_ctrl.md
Name: ah_decode_route_ctrl

Overview:
Programmable address-decode controller and request router for the ingress packet path. It holds NUM_CLIENTS configurable inclusive address windows (base/limit) and accepts one request at a time on a valid/ready handshake. It decodes the 34-bit packet field against the windows and dispatches the request to exactly one client with a per-client valid/ready handshake. Requests that hit no window are reported as decode errors and counted.

Parameters:
NUM_CLIENTS, 10, number of decode windows/clients (1..16)
ADDR_W, 34, width of ingress_pkt_field and window bounds
IDX_W, 4, width of cfg_idx (ceil(log2(NUM_CLIENTS)), minimum 1)
ERR_CNT_W, 16, width of the saturating error counter

Ports:
clk  in  1  single clock; all state on rising edge
rst  in  1  asynchronous, active-high reset
cfg_wr_en  in  1  write one window entry
cfg_idx  in  IDX_W  window index to write
cfg_base  in  ADDR_W  inclusive lower bound
cfg_limit  in  ADDR_W  inclusive upper bound
cfg_enable  in  1  entry enable
cfg_ready  out  1  config write accepted when cfg_wr_en & cfg_ready
req_valid  in  1  ingress request valid
req_ready  out  1  ingress request accepted when req_valid & req_ready
ingress_pkt_field  in  ADDR_W  request address/field
dsp_valid  out  NUM_CLIENTS  one-hot dispatch valid
dsp_ready  in  NUM_CLIENTS  per-client ready
dsp_addr  out  ADDR_W  captured field, valid while any dsp_valid bit is set
dec_err  out  1  one-cycle pulse on decode miss
err_addr  out  ADDR_W  field of the last missed request
err_count  out  ERR_CNT_W  saturating count of decode misses
busy  out  1  high in any state other than IDLE

Behaviour:
- FSM states: IDLE, DECODE, DISPATCH, ERROR.
- Reset values: state IDLE; all entries disabled with base=0 and limit=0; dsp_valid=0; dsp_addr=0; dec_err=0; err_addr=0; err_count=0; busy=0. Reset in any state returns immediately (asynchronously) to these values and drops any pending dispatch.
- cfg_ready = (state==IDLE).
- req_ready = (state==IDLE) & ~cfg_wr_en. A config write in the same cycle takes priority and the request is held off.
- Config writes take effect on the next cycle. A write with cfg_idx >= NUM_CLIENTS is accepted and ignored.
- IDLE: on req accept, capture ingress_pkt_field into an address register and go to DECODE.
- DECODE (1 cycle):
  - match[i] = en[i] & (addr >= base[i]) & (addr <= limit[i]), using unsigned ADDR_W comparisons.
  - An entry with base > limit never matches.
  - Overlapping windows: the lowest matching index wins.
  - Any match: register the one-hot select and go to DISPATCH.
  - No match: go to ERROR.
- DISPATCH:
  - dsp_valid = select and dsp_addr = the captured address, held stable until dsp_ready[sel] is high.
  - Ready bits of non-selected clients are ignored.
  - On handshake, return to IDLE (dsp_valid=0 next cycle).
  - No timeout.
- ERROR (1 cycle):
  - dec_err=1 and err_addr=the captured address.
  - err_count increments and saturates at all-ones.
  - Then go to IDLE.
- Latency: request accepted in cycle N → dsp_valid or dec_err asserted in cycle N+2. With an immediate dsp_ready, the next req_ready is asserted in cycle N+3.
- Throughput: one request in flight; no pipelining.
- A window reprogrammed while busy is impossible (cfg_ready=0), so the decode result is always consistent with the table at accept time.

Test Plan:
- After reset, program entry 0 = [0x0000_0000, 0x0000_0FFF] enabled. Send field 0x0000_0800 with dsp_ready[0]=1 → dsp_valid=10'b0000000001 two cycles after accept, dsp_addr=0x0000_0800, held for exactly one cycle.
- Overlap: entry 1 = [0x1000, 0x3FFF] and entry 2 = [0x2000, 0x5FFF]. Send field 0x2800 → dsp_valid bit 1 only. Send field 0x4000 → bit 2 only. Boundary fields 0x1000 and 0x3FFF → bit 1. Field 0x6000 → dec_err pulse, err_addr=0x6000, err_count=1.
- Backpressure: hold dsp_ready[3]=0 for 5 cycles on a hit to entry 3; toggle dsp_ready[4] → dsp_valid[3] and dsp_addr stay stable, req_ready=0, busy=1 throughout; completes one cycle after dsp_ready[3]=1.
- Config/request collision: cfg_wr_en and req_valid both high in IDLE → write applied, req_ready=0 that cycle. The request is accepted next cycle and decoded with the new entry. Write with cfg_idx=12 → no table change.
- Edge entries: entry with base=0x5000, limit=0x4000 enabled, and a disabled entry covering all addresses → field 0x4800 produces dec_err. Also drive 65537 misses → err_count stops at 0xFFFF.
- Reset mid-DISPATCH with dsp_valid[5]=1 → dsp_valid=0, busy=0, err_count=0 and all entries disabled asynchronously. The next request produces dec_err.
